// File: rtl/graying_pkg.sv
// Shared types and constants for the graying_multi RGB-to-gray block.
package graying_pkg;

  typedef enum logic [1:0] {
    M_WEIGHTED = 2'd0,
    M_MAX      = 2'd1,
    M_MIN      = 2'd2,
    M_GREEN    = 2'd3
  } method_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // BT.601 luma weights scaled for 8 fraction bits
  localparam int BT601_R = 77;
  localparam int BT601_G = 150;
  localparam int BT601_B = 29;

  // cnt value at which the request's result lands in the output register
  localparam int CALC_LAST = 2;

  function automatic int acc_width(input int color_width, input int coef_width);
    return 2 + color_width + coef_width;
  endfunction

endpackage

// File: rtl/graying_multi_if.sv
// Pixel-in / gray-out bundle; master is the pixel source, slave is the converter.
interface graying_multi_if #(
  parameter int color_width = 8,
  parameter int coef_width  = 8
);
  logic                       in_enable;
  logic [3*color_width-1:0]   in_data;
  logic [1:0]                 method;
  logic [coef_width-1:0]      coef_r;
  logic [coef_width-1:0]      coef_g;
  logic [coef_width-1:0]      coef_b;
  logic                       out_ready;
  logic [color_width-1:0]     out_data;

  modport master (
    output in_enable, in_data, method, coef_r, coef_g, coef_b,
    input  out_ready, out_data
  );

  modport slave (
    input  in_enable, in_data, method, coef_r, coef_g, coef_b,
    output out_ready, out_data
  );
endinterface

// File: rtl/graying_core.sv
// Three-stage gray datapath: capture, products/compare, sum+round+saturate.
// flush kills every in-flight pixel and blocks the output register update.
module graying_core
  import graying_pkg::*;
#(
  parameter int color_width = 8,
  parameter int coef_width  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     valid_in,
  input  logic [3*color_width-1:0] data_in,
  input  logic [1:0]               method_in,
  input  logic [coef_width-1:0]    coef_r,
  input  logic [coef_width-1:0]    coef_g,
  input  logic [coef_width-1:0]    coef_b,
  output logic                     valid_out,
  output logic [color_width-1:0]   data_out
);

  localparam int AW = acc_width(color_width, coef_width);
  localparam int PW = color_width + coef_width;
  localparam logic [AW-1:0] RND  = AW'(1) << (coef_width - 1);
  localparam logic [AW-1:0] MAXV = (AW'(1) << color_width) - AW'(1);

  logic                   s1_valid;
  logic [color_width-1:0] s1_r, s1_g, s1_b;
  method_t                s1_method;
  logic [coef_width-1:0]  s1_cr, s1_cg, s1_cb;

  logic                   s2_valid;
  logic [PW-1:0]          s2_pr, s2_pg, s2_pb;
  logic [color_width-1:0] s2_sel;
  method_t                s2_method;

  logic [PW-1:0]          prod_r, prod_g, prod_b;
  logic [color_width-1:0] sel_c;
  logic [AW-1:0]          acc_c;
  logic [AW-1:0]          y_c;
  logic [color_width-1:0] result_c;

  assign prod_r = PW'(s1_r) * PW'(s1_cr);
  assign prod_g = PW'(s1_g) * PW'(s1_cg);
  assign prod_b = PW'(s1_b) * PW'(s1_cb);

  always_comb begin
    sel_c = s1_g;
    case (s1_method)
      M_MAX: begin
        sel_c = s1_r;
        if (s1_g > sel_c) sel_c = s1_g;
        if (s1_b > sel_c) sel_c = s1_b;
      end
      M_MIN: begin
        sel_c = s1_r;
        if (s1_g < sel_c) sel_c = s1_g;
        if (s1_b < sel_c) sel_c = s1_b;
      end
      default: sel_c = s1_g;
    endcase
  end

  assign acc_c = AW'(s2_pr) + AW'(s2_pg) + AW'(s2_pb) + RND;
  assign y_c   = acc_c >> coef_width;

  always_comb begin
    result_c = s2_sel;
    if (s2_method == M_WEIGHTED) begin
      if (y_c > MAXV) result_c = '1;
      else            result_c = y_c[color_width-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_r      <= '0;
      s1_g      <= '0;
      s1_b      <= '0;
      s1_method <= M_WEIGHTED;
      s1_cr     <= '0;
      s1_cg     <= '0;
      s1_cb     <= '0;
      s2_valid  <= 1'b0;
      s2_pr     <= '0;
      s2_pg     <= '0;
      s2_pb     <= '0;
      s2_sel    <= '0;
      s2_method <= M_WEIGHTED;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      s1_valid  <= valid_in & ~flush;
      s2_valid  <= s1_valid & ~flush;
      valid_out <= s2_valid & ~flush;
      if (valid_in) begin
        s1_r      <= data_in[3*color_width-1 -: color_width];
        s1_g      <= data_in[2*color_width-1 -: color_width];
        s1_b      <= data_in[color_width-1:0];
        s1_method <= method_t'(method_in);
        s1_cr     <= coef_r;
        s1_cg     <= coef_g;
        s1_cb     <= coef_b;
      end
      if (s1_valid) begin
        s2_pr     <= prod_r;
        s2_pg     <= prod_g;
        s2_pb     <= prod_b;
        s2_sel    <= sel_c;
        s2_method <= s1_method;
      end
      // bubbles and aborted requests leave the last result on the output
      if (s2_valid && !flush) data_out <= result_c;
    end
  end

endmodule

// File: rtl/graying_multi.sv
// RGB to gray converter: streaming pipeline (work_mode 0) or req/ack single-shot (work_mode 1).
//   state   | meaning
//   IDLE    | waiting for request; request edge captures the pixel
//   CALC    | pixel in the datapath, cnt tracks stage; release aborts
//   DONE    | result held with out_ready=1 until request released
module graying_multi
  import graying_pkg::*;
#(
  parameter int work_mode   = 0,
  parameter int color_width = 8,
  parameter int coef_width  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  graying_multi_if.slave   bus
);

  logic                   core_valid_in;
  logic                   core_flush;
  logic                   core_valid_out;
  logic [color_width-1:0] core_data;

  graying_core #(
    .color_width (color_width),
    .coef_width  (coef_width)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (core_flush),
    .valid_in  (core_valid_in),
    .data_in   (bus.in_data),
    .method_in (bus.method),
    .coef_r    (bus.coef_r),
    .coef_g    (bus.coef_g),
    .coef_b    (bus.coef_b),
    .valid_out (core_valid_out),
    .data_out  (core_data)
  );

  assign bus.out_data = core_data;

  generate
    if (work_mode == 0) begin : g_pipe
      assign core_valid_in = bus.in_enable;
      assign core_flush    = 1'b0;
      assign bus.out_ready = core_valid_out;
    end else begin : g_reqack
      state_t     state, state_nx;
      logic [1:0] cnt, cnt_nx;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state <= ST_IDLE;
          cnt   <= '0;
        end else begin
          state <= state_nx;
          cnt   <= cnt_nx;
        end
      end

      always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        core_valid_in = 1'b0;
        core_flush    = 1'b0;
        case (state)
          ST_IDLE: begin
            if (bus.in_enable) begin
              core_valid_in = 1'b1;
              cnt_nx        = '0;
              state_nx      = ST_CALC;
            end
          end
          ST_CALC: begin
            cnt_nx = cnt + 2'd1;
            if (!bus.in_enable) begin
              core_flush = 1'b1;
              cnt_nx     = '0;
              state_nx   = ST_IDLE;
            end else if (cnt_nx == 2'(CALC_LAST)) begin
              state_nx = ST_DONE;
            end
          end
          ST_DONE: begin
            if (!bus.in_enable) state_nx = ST_IDLE;
          end
          default: state_nx = ST_IDLE;
        endcase
      end

      assign bus.out_ready = (state == ST_DONE);
    end
  endgenerate

endmodule
